dm_access_unit: RTL and testbench

//  Initiator side of the data-memory interface: sits between the CPU datapath and dm.

---
 rtl/dm_access_pkg.sv | 29 ++
 rtl/dm_lane.sv | 42 ++++
 rtl/dm_access_unit.sv | 113 +++++++++++
 tb/tb_dm_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access unit: size codes, FSM states and
// the alignment rule that decides whether an access is rejected up front.
package dm_access_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;
  localparam size_t SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // An access is rejected when its size is illegal or it is not naturally aligned.
  function automatic logic is_bad_access(input size_t size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_bad_access = 1'b0;
      SZ_HALF: is_bad_access = offset[0];
      SZ_WORD: is_bad_access = (offset != 2'b00);
      default: is_bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Little-endian lane helper: extracts a byte/half/word from a dm word (with
// optional sign extension) and merges right-aligned store data into a dm word.
module dm_lane
  import dm_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    extracted = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        extracted = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        merged[{offset, 3'b000} +: 8] = data[7:0];
      end
      SZ_HALF: begin
        extracted = {{16{sign_ext & half_sel[15]}}, half_sel};
        if (offset[1]) merged[31:16] = data[15:0];
        else           merged[15:0]  = data[15:0];
      end
      default: begin
        extracted = word;
        merged    = data;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// CPU-side data-memory access unit: converts byte/half/word loads and stores into
// word-only dm accesses, using read-modify-write for sub-word stores.
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_MemWrite,
  output logic              dm_MemRead,
  input  logic [31:0]       dm_rdata
);

  state_e      state;
  logic        we_q;
  size_t       size_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] merge_q;

  logic [31:0] lane_word;
  logic [31:0] lane_extracted;
  logic [31:0] lane_merged;
  logic        unused_addr_hi;

  // Bytes above the dm window are deliberately dropped so addresses wrap.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // In RD the lane logic works on live dm data; in WR it works on the captured word.
  assign lane_word = dm_MemRead ? dm_rdata : merge_q;

  dm_lane u_lane (
    .word      (lane_word),
    .data      (wdata_q),
    .offset    (off_q),
    .size      (size_q),
    .sign_ext  (sign_q),
    .extracted (lane_extracted),
    .merged    (lane_merged)
  );

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign dm_MemRead  = (state == RD);
  assign dm_MemWrite = (state == WR);
  assign dm_wdata    = dm_MemWrite ? lane_merged : 32'h0;
  assign busy        = (state != IDLE);
  assign done        = (state == RESP);
  assign err         = done & err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      merge_q <= 32'h0;
      rdata   <= 32'h0;
      dm_addr <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            sign_q  <= sign_ext;
            off_q   <= addr[1:0];
            wdata_q <= wdata;
            dm_addr <= addr[ADDR_W+1:2];
            if (is_bad_access(size, addr[1:0])) begin
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              err_q <= 1'b0;
              state <= (we && size == SZ_WORD) ? WR : RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            merge_q <= dm_rdata;
            state   <= WR;
          end else begin
            rdata <= lane_extracted;
            state <= RESP;
          end
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit with a behavioural word-wide dm model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_MemWrite;
  logic        dm_MemRead;
  logic [31:0] dm_rdata;

  dm_access_unit #(.ADDR_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .size        (size),
    .sign_ext    (sign_ext),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_MemWrite (dm_MemWrite),
    .dm_MemRead  (dm_MemRead),
    .dm_rdata    (dm_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (dm_MemWrite) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = mem[dm_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [9:0]  waddr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] shadow [0:1023];
  logic [31:0] model_rdata;

  task automatic run_op(input string tag, input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] d, input bit poke);
    exp_t        e;
    exp_t        p;
    logic [1:0]  off;
    logic [9:0]  wa;
    logic [31:0] lane;
    logic [31:0] mask;
    logic [9:0]  seen_waddr;
    int          lat;
    int          rd_n;
    int          wr_n;
    int          extra;

    off = a[1:0];
    wa  = a[11:2];
    e.err = 1'b0; e.lat = 0; e.rd_n = 0; e.wr_n = 0; e.waddr = wa;
    if (sz == 2'b11 || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00)) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!w) begin
      e.lat = 2; e.rd_n = 1;
      lane = shadow[wa] >> (8 * off);
      case (sz)
        2'b00:   model_rdata = sx ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
        2'b01:   model_rdata = sx ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
        default: model_rdata = shadow[wa];
      endcase
    end else if (sz == 2'b10) begin
      e.lat = 2; e.wr_n = 1;
      shadow[wa] = d;
    end else begin
      e.lat = 3; e.rd_n = 1; e.wr_n = 1;
      mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
      shadow[wa] = (shadow[wa] & ~mask) | ((d << (8 * off)) & mask);
    end
    e.rdata = model_rdata;
    sb_q.push_back(e);

    @(negedge clk);
    check({tag, "_idle"}, {31'b0, busy}, 32'h0);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk);
    lat = 0; rd_n = 0; wr_n = 0; seen_waddr = '0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "_busy"}, {31'b0, busy}, 32'h1);
        req = poke;
        if (poke) begin
          addr = {a[31:2], 2'b00} + 32'h4; we = 1'b1; size = 2'b10; wdata = ~d;
        end
      end else if (lat == 2) begin
        req = 1'b0;
      end
      if (dm_MemRead || dm_MemWrite)
        check({tag, "_rw_excl"}, {31'b0, dm_MemRead & dm_MemWrite}, 32'h0);
      rd_n += int'(dm_MemRead);
      wr_n += int'(dm_MemWrite);
      if (dm_MemWrite) seen_waddr = dm_addr;
      if (done) break;
    end
    req = 1'b0;

    p = sb_q.pop_front();
    check({tag, "_lat"}, lat, p.lat);
    check({tag, "_err"}, {31'b0, err}, {31'b0, p.err});
    check({tag, "_rdata"}, rdata, p.rdata);
    check({tag, "_rd_n"}, rd_n, p.rd_n);
    check({tag, "_wr_n"}, wr_n, p.wr_n);
    if (p.wr_n > 0) check({tag, "_waddr"}, {22'h0, seen_waddr}, {22'h0, p.waddr});
    if (w && !p.err) check({tag, "_mem"}, mem[wa], shadow[wa]);
    if (poke) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        extra += int'(done);
      end
      check({tag, "_extra_done"}, extra, 0);
      check({tag, "_poke_mem"}, mem[wa + 10'd1], shadow[wa + 10'd1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          extra;

    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, busy}, 32'h0);
    check("rst_done",  {31'b0, done}, 32'h0);
    check("rst_err",   {31'b0, err}, 32'h0);
    check("rst_mrd",   {31'b0, dm_MemRead}, 32'h0);
    check("rst_mwr",   {31'b0, dm_MemWrite}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_daddr", {22'h0, dm_addr}, 32'h0);
    check("rst_wdata", dm_wdata, 32'h0);
    reset = 1'b1;

    // Sub-word store read-modify-write.
    run_op("sw_pre", 1'b1, 2'b10, 1'b0, 32'h000, 32'h1122_3344, 1'b0);
    run_op("sb_rmw", 1'b1, 2'b00, 1'b0, 32'h001, 32'h0000_00AB, 1'b0);
    check("sb_rmw_word", mem[0], 32'h1122_AB44);

    // Lane extraction with sign and zero extension.
    run_op("sw_pre3", 1'b1, 2'b10, 1'b0, 32'h000, 32'h80FF_7F01, 1'b0);
    run_op("lb_sx", 1'b0, 2'b00, 1'b1, 32'h002, 32'h0, 1'b0);
    check("lb_sx_val", rdata, 32'hFFFF_FFFF);
    run_op("lbu", 1'b0, 2'b00, 1'b0, 32'h003, 32'h0, 1'b0);
    check("lbu_val", rdata, 32'h0000_0080);
    run_op("lh_sx", 1'b0, 2'b01, 1'b1, 32'h000, 32'h0, 1'b0);
    check("lh_sx_val", rdata, 32'h0000_7F01);

    // Word store and load back.
    run_op("sw4", 1'b1, 2'b10, 1'b0, 32'h004, 32'hDEAD_BEEF, 1'b0);
    run_op("lw4", 1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 1'b0);
    check("lw4_val", rdata, 32'hDEAD_BEEF);

    // Errors leave rdata alone and touch no memory.
    run_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h002, 32'h0, 1'b0);
    check("lw_mis_hold", rdata, 32'hDEAD_BEEF);
    run_op("sz_ill", 1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 1'b0);
    run_op("sh_mis", 1'b1, 2'b01, 1'b0, 32'h005, 32'h1234, 1'b0);

    // Address wrap plus a request pulsed while busy.
    run_op("sw_zero", 1'b1, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0);
    run_op("sh_wrap", 1'b1, 2'b01, 1'b0, 32'h1002, 32'h0000_5566, 1'b1);
    check("sh_wrap_word", mem[0], 32'h5566_0000);

    // Randomised mix over a small window with random high address bits.
    for (int i = 0; i < 8; i++)
      run_op("rnd_init", 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a  = $urandom & ~32'h0000_0FE0;
      sz = 2'($urandom_range(0, 3));
      run_op("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of the write cycle of a sub-word store.
    run_op("sw_pre1", 1'b1, 2'b10, 1'b0, 32'h000, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h001; wdata = 32'h12;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("abort_wr_before", {31'b0, dm_MemWrite}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_mwr",   {31'b0, dm_MemWrite}, 32'h0);
    check("abort_mrd",   {31'b0, dm_MemRead}, 32'h0);
    check("abort_busy",  {31'b0, busy}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_wdata", dm_wdata, 32'h0);
    model_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      extra += int'(done);
    end
    check("abort_no_done", extra, 0);
    check("abort_mem", mem[0], 32'hCAFE_F00D);
    run_op("abort_lw", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
